// File: rtl/seq_restoring_divider.sv
// Sequential restoring divider: one quotient bit per clock, WIDTH iterations per divide.
// Optional two's-complement operation is enabled by defining SIGNED_DIV_EN.
//
// state   | meaning
// IDLE    | waiting for Run; last result held on the outputs
// COMPUTE | shift / trial-subtract / restore, one bit per edge
// DONE    | result valid, held until Run drops
module seq_restoring_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             run_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             div_by_zero_o
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] q_q, r_q, d_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] quot_q, rem_q;
  logic             busy_q, done_q, dz_q;

  logic [WIDTH:0]   trial_d;
  logic [WIDTH-1:0] q_d, r_d;
  logic [WIDTH-1:0] dvd_mag, div_mag;
  logic [WIDTH-1:0] quot_fin, rem_fin;
  logic             cnt_last;

  assign trial_d  = {r_q, q_q[WIDTH-1]} - {1'b0, d_q};
  assign r_d      = trial_d[WIDTH] ? {r_q[WIDTH-2:0], q_q[WIDTH-1]} : trial_d[WIDTH-1:0];
  assign q_d      = {q_q[WIDTH-2:0], ~trial_d[WIDTH]};
  assign cnt_last = (cnt_q == CW'(WIDTH - 1));

`ifdef SIGNED_DIV_EN
  logic neg_quot_q, neg_rem_q;

  // Magnitudes feed the unsigned core; the most-negative value maps to itself,
  // which is still the correct unsigned magnitude.
  assign dvd_mag  = dividend_i[WIDTH-1] ? -dividend_i : dividend_i;
  assign div_mag  = divisor_i[WIDTH-1]  ? -divisor_i  : divisor_i;
  assign quot_fin = neg_quot_q ? -q_d : q_d;
  assign rem_fin  = neg_rem_q  ? -r_d : r_d;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
    end else if (state_q == IDLE && run_i) begin
      neg_quot_q <= dividend_i[WIDTH-1] ^ divisor_i[WIDTH-1];
      neg_rem_q  <= dividend_i[WIDTH-1];
    end
  end
`else
  assign dvd_mag  = dividend_i;
  assign div_mag  = divisor_i;
  assign quot_fin = q_d;
  assign rem_fin  = r_d;
`endif

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      q_q     <= '0;
      r_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (run_i) begin
            if (divisor_i == '0) begin
              state_q <= DONE;
              quot_q  <= '1;
              rem_q   <= dividend_i;
              dz_q    <= 1'b1;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              state_q <= COMPUTE;
              d_q     <= div_mag;
              q_q     <= dvd_mag;
              r_q     <= '0;
              cnt_q   <= '0;
              dz_q    <= 1'b0;
              busy_q  <= 1'b1;
            end
          end
        end
        COMPUTE: begin
          q_q   <= q_d;
          r_q   <= r_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_last) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            quot_q  <= quot_fin;
            rem_q   <= rem_fin;
          end
        end
        DONE: begin
          if (!run_i) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign quotient_o    = quot_q;
  assign remainder_o   = rem_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign div_by_zero_o = dz_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench for seq_restoring_divider: directed and random divides
// against an arithmetic reference model (signed model when SIGNED_DIV_EN is defined).
module tb_seq_restoring_divider;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       run = 1'b0;
  logic [7:0] dividend = '0;
  logic [7:0] divisor = '0;
  logic [7:0] quotient, remainder;
  logic       busy, done, dbz;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] prev_q = '0;
  logic [7:0] prev_r = '0;
  logic       prev_dz = 1'b0;

  always #5 clk = ~clk;

  seq_restoring_divider #(.WIDTH(8)) dut (
    .clk_i(clk), .reset_i(reset), .run_i(run),
    .dividend_i(dividend), .divisor_i(divisor),
    .quotient_o(quotient), .remainder_o(remainder),
    .busy_o(busy), .done_o(done), .div_by_zero_o(dbz)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic [7:0] a, input logic [7:0] b,
                                output logic [7:0] q, output logic [7:0] r, output logic dz);
`ifdef SIGNED_DIV_EN
    int sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    if (b == 8'd0) begin
      q = 8'hFF; r = a; dz = 1'b1;
    end else if (sa == -128 && sb == -1) begin
      q = 8'h80; r = 8'h00; dz = 1'b0;
    end else begin
      q = 8'(sa / sb); r = 8'(sa % sb); dz = 1'b0;
    end
`else
    if (b == 8'd0) begin
      q = 8'hFF; r = a; dz = 1'b1;
    end else begin
      q = a / b; r = a % b; dz = 1'b0;
    end
`endif
  endfunction

  // One complete divide: start, step through latency, hold in DONE, release Run.
  task automatic run_div(input logic [7:0] a, input logic [7:0] b, input int hold, input bit scramble);
    logic [7:0] eq, er;
    logic       edz;
    model(a, b, eq, er, edz);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    run      = 1'b1;
    @(posedge clk); #1;
    if (b == 8'd0) begin
      check("dz_done", done, 1);
      check("dz_busy", busy, 0);
    end else begin
      for (int e = 2; e <= 9; e++) begin
        check("busy_compute", busy, 1);
        check("done_compute", done, 0);
        check("q_held_compute", quotient, prev_q);
        check("r_held_compute", remainder, prev_r);
        check("dz_clear_compute", dbz, 0);
        @(negedge clk);
        if (scramble) begin
          dividend = 8'($urandom);
          divisor  = 8'($urandom);
          run      = 1'($urandom);
        end
        @(posedge clk); #1;
      end
      check("done_latency", done, 1);
      check("busy_end", busy, 0);
    end
    check("quotient", quotient, eq);
    check("remainder", remainder, er);
    check("div_by_zero", dbz, edz);
    @(negedge clk);
    run = 1'b1;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check("hold_done", done, 1);
      check("hold_busy", busy, 0);
      check("hold_q", quotient, eq);
    end
    @(negedge clk);
    run = 1'b0;
    @(posedge clk); #1;
    check("idle_done", done, 0);
    check("idle_busy", busy, 0);
    check("idle_q", quotient, eq);
    check("idle_r", remainder, er);
    check("idle_dz", dbz, edz);
    prev_q  = eq;
    prev_r  = er;
    prev_dz = edz;
  endtask

  initial begin
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_q", quotient, 0);
    check("rst_r", remainder, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_dz", dbz, 0);
    @(negedge clk);
    reset = 1'b0;

    run_div(8'd100, 8'd7, 0, 1'b0);
    run_div(8'd255, 8'd1, 0, 1'b0);
    run_div(8'd3, 8'd200, 0, 1'b0);
    run_div(8'd5, 8'd0, 0, 1'b0);
    run_div(8'd0, 8'd13, 0, 1'b0);
    run_div(8'd255, 8'd255, 0, 1'b0);

    // Abort mid-compute: reset lands on the 4th COMPUTE edge.
    @(negedge clk);
    dividend = 8'd200;
    divisor  = 8'd9;
    run      = 1'b1;
    @(posedge clk);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    run   = 1'b0;
    @(posedge clk); #1;
    check("abort_q", quotient, 0);
    check("abort_r", remainder, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_dz", dbz, 0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    check("abort_idle_busy", busy, 0);
    check("abort_idle_done", done, 0);
    prev_q = 8'd0;
    prev_r = 8'd0;
    run_div(8'd200, 8'd9, 0, 1'b0);

    // Run held through DONE must not retrigger; operands scrambled during COMPUTE.
    run_div(8'd77, 8'd6, 20, 1'b0);
    run_div(8'd250, 8'd11, 3, 1'b1);

`ifdef SIGNED_DIV_EN
    run_div(8'h9C, 8'h07, 0, 1'b0);
    run_div(8'h80, 8'hFF, 0, 1'b0);
    run_div(8'h64, 8'hF9, 0, 1'b0);
    run_div(8'h9C, 8'hF9, 0, 1'b0);
    run_div(8'h80, 8'h00, 0, 1'b0);
`endif

    for (int n = 0; n < 40; n++) begin
      logic [7:0] a, b;
      a = 8'($urandom);
      b = (n % 10 == 9) ? 8'd0 : 8'($urandom);
      run_div(a, b, int'($urandom_range(0, 2)), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seq_restoring_divider.md
Name: seq_restoring_divider

Overview:
Sequential restoring divider. Computes quotient and remainder of two WIDTH-bit operands, one quotient bit per clock. Inverse-direction companion to the lab's shift-add multiplier datapath: it uses subtract and restore instead of add and shift. Sits beside the multiplier under the same top level. It is driven by the Run switch, and its operands come from the same switch and register bank.

Parameters:
WIDTH, 8, operand/result width in bits (quotient and remainder both WIDTH).

Ports:
Clk  input  1  system clock, all state updates on rising edge
Reset  input  1  synchronous, active-high reset
Run  input  1  level-held start request; sampled only in IDLE and DONE
Dividend  input  WIDTH  dividend, captured on the start edge
Divisor  input  WIDTH  divisor, captured on the start edge
Quotient  output  WIDTH  quotient result
Remainder  output  WIDTH  remainder result
Busy  output  1  high while iterating
Done  output  1  high while a result is held in DONE
DivByZero  output  1  high in DONE when the captured divisor was 0

Behaviour:
- One clock (Clk). Reset is synchronous and active-high. On Reset: state=IDLE; Quotient=0, Remainder=0, Busy=0, Done=0, DivByZero=0; iteration counter=0.
- Reset has priority over every other event. Reset mid-COMPUTE aborts: outputs return to reset values on that edge and no Done is produced.
- States: IDLE, COMPUTE, DONE.
- IDLE, Run=1 and Divisor!=0: on this edge the block does the following.
  - Captures D=Divisor.
  - Loads Q=Dividend and R=0, clears the counter and clears DivByZero.
  - Goes to COMPUTE with Busy=1.
- IDLE, Run=1 and Divisor==0: on this edge the block goes directly to DONE.
  - Quotient = all ones (2^WIDTH-1) and Remainder = Dividend.
  - DivByZero=1, Done=1, Busy=0.
- COMPUTE, each edge performs one iteration:
  - Shift {R,Q} left by 1.
  - Trial subtraction is WIDTH+1 bits: T = {R[WIDTH-1:0],Q[WIDTH-1]} - {0,D}.
  - If T[WIDTH]==0 (no borrow): R=T[WIDTH-1:0] and the new Q[0]=1.
  - Otherwise: R is restored (the shifted value is kept) and the new Q[0]=0.
  - Counter increments each iteration.
- COMPUTE ends after exactly WIDTH iterations. On the WIDTH-th iteration edge the state goes to DONE, Busy=0, Done=1, Quotient=Q and Remainder=R.
- Latency: Done is visible after the (WIDTH+1)-th rising edge, counting the edge that sampled Run. That is 9 edges for WIDTH=8. The divide-by-zero path takes 1 edge.
- Run changes during COMPUTE are ignored. Operand input changes after the start edge are ignored.
- DONE holds all outputs while Run=1. When Run=0 the block returns to IDLE on that edge with Done=0.
- Quotient, Remainder and DivByZero keep their values in IDLE until the next start.
- Holding Run=1 continuously does not retrigger. A new start requires Run to fall and then rise while in IDLE.
- Quotient and Remainder do not change during COMPUTE; they show the previous result. Internal Q and R are separate registers.
- Invariants for unsigned non-zero divisors: Dividend = Quotient*Divisor + Remainder, and Remainder < Divisor.

Optional Feature:
Macro: SIGNED_DIV_EN.
- Defined: operands are two's complement.
  - On the start edge, magnitudes are captured and the operand signs are latched.
  - The unsigned core runs unchanged.
  - On the DONE transition, Quotient is negated if the signs differ. Remainder takes the sign of the dividend, so division truncates toward zero.
  - Overflow case, most-negative divided by -1 (e.g. 0x80/0xFF): Quotient=0x80, Remainder=0, DivByZero=0.
  - Divide by zero: Quotient=all ones, Remainder=Dividend, DivByZero=1.
  - Latency is unchanged (WIDTH+1 edges); the sign fix-up is folded into the final edge.
- Undefined: purely unsigned operation. There is no sign logic and no extra ports.

Test Plan:
- Reset, then Dividend=100, Divisor=7, Run=1 held -> Busy high for 8 cycles; Done=1 after the 9th edge; Quotient=14, Remainder=2, DivByZero=0; Run=0 -> IDLE, Done=0, results held.
- Dividend=255, Divisor=1 -> Quotient=255, Remainder=0. Dividend=3, Divisor=200 -> Quotient=0, Remainder=3.
- Dividend=5, Divisor=0, Run=1 -> after 1 edge: Done=1, DivByZero=1, Quotient=0xFF, Remainder=5, Busy never asserted.
- Start 200/9, assert Reset on the 4th COMPUTE edge -> next cycle all outputs 0, state IDLE; restart with Run toggled -> Quotient=22, Remainder=2.
- Run held high across DONE for 20 cycles -> exactly one computation. Change Dividend/Divisor during COMPUTE -> the result reflects the captured operands.
- SIGNED_DIV_EN: -100/7 (0x9C/0x07) -> Quotient=0xF2 (-14), Remainder=0xFE (-2). 0x80/0xFF -> Quotient=0x80, Remainder=0.
